// File: rtl/obi_arbiter_bridge.sv
// rtl/obi_arbiter_bridge.sv - N-port OBI arbiter sharing one memory port, in-order response routing.
// Define OBI_BRIDGE_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module obi_arbiter_bridge #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]          web_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [NUM_PORTS-1:0]          rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          mem_req_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_web_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          err_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] winner, head;
  logic             any_req, handshake, pop;

`ifndef OBI_BRIDGE_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_last_q;
`endif

  assign any_req   = rst && (|req_i);
  assign mem_req_o = any_req && (count_q < CNT_W'(MAX_OUTSTANDING));
  assign handshake = mem_req_o && mem_gnt_i;
  assign pop       = rst && mem_rvalid_i && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign rdata_o   = rst ? mem_rdata_i : '0;
  assign err_o     = err_q;

  // Lowest requesting index first; round-robin then prefers the lowest index above rr_last.
  always_comb begin
    winner = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (req_i[p]) winner = IDX_W'(p);
    end
`ifndef OBI_BRIDGE_FIXED_PRIO_EN
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (req_i[p] && (IDX_W'(p) > rr_last_q)) winner = IDX_W'(p);
    end
`endif
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_web_o   = 1'b1;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (any_req && (winner == IDX_W'(p))) begin
        mem_addr_o  = addr_i[p*ADDR_W +: ADDR_W];
        mem_web_o   = web_i[p];
        mem_wdata_o = wdata_i[p*DATA_W +: DATA_W];
      end
      gnt_o[p]    = handshake && (winner == IDX_W'(p));
      rvalid_o[p] = pop && (head == IDX_W'(p));
    end
  end

  always_comb begin
    count_d = count_q;
    if (handshake && !pop)      count_d = count_q + 1'b1;
    else if (!handshake && pop) count_d = count_q - 1'b1;
    err_d = err_q || (mem_rvalid_i && (count_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
`ifndef OBI_BRIDGE_FIXED_PRIO_EN
      rr_last_q <= IDX_W'(NUM_PORTS - 1);
`endif
    end else begin
      if (handshake) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
`ifndef OBI_BRIDGE_FIXED_PRIO_EN
        rr_last_q        <= winner;
`endif
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_arbiter_bridge.sv
// tb/tb_obi_arbiter_bridge.sv - vector table, reset sequences and randomized model check for obi_arbiter_bridge.
module tb_obi_arbiter_bridge;

`ifdef OBI_BRIDGE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_i = '0;
  logic [63:0] addr_i = '0;
  logic [1:0]  web_i = 2'b11;
  logic [63:0] wdata_i = '0;
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_web_o, err_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  obi_arbiter_bridge #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .web_i(web_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_web_o(mem_web_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic [31:0] rdata,
                              logic [1:0] e_gnt, logic [1:0] e_rv, logic e_req,
                              logic [31:0] e_addr, logic e_err);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_req = e_req; v.e_addr = e_addr; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic g, input logic rv, input logic [31:0] rd);
    req_i = req; mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    addr_i = {32'h200, 32'h100}; wdata_i = {32'hB1, 32'hA0}; web_i = 2'b11;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},    32'(gnt_o), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'h0);
    chk({tag, "_memreq"}, 32'(mem_req_o), 32'h0);
    chk({tag, "_addr"},   mem_addr_o, 32'h0);
    chk({tag, "_web"},    32'(mem_web_o), 32'h1);
    chk({tag, "_wdata"},  mem_wdata_o, 32'h0);
    chk({tag, "_rdata"},  rdata_o, 32'h0);
    chk({tag, "_err"},    32'(err_o), 32'h0);
  endtask

  // Reference model state for the randomized phase
  int          mq[$];
  int          rr_last;
  bit          pend[2];
  logic [31:0] paddr[2], pwdata[2];
  logic        pweb[2];

  initial begin
    logic [1:0] alt1, alt0;
    logic [31:0] a1;
    alt1 = FIXED ? 2'b01 : 2'b10;
    a1   = FIXED ? 32'h100 : 32'h200;

    tbl[0]  = mk(2'b01, 1, 0, 0,            2'b01, 2'b00, 1, 32'h100, 0);
    tbl[1]  = mk(2'b00, 1, 0, 0,            2'b00, 2'b00, 0, 32'h0,   0);
    tbl[2]  = mk(2'b00, 0, 1, 32'hDEADBEEF, 2'b00, 2'b01, 0, 32'h0,   0);
    tbl[3]  = mk(2'b11, 1, 0, 0,            alt1,  2'b00, 1, a1,      0);
    tbl[4]  = mk(2'b11, 1, 0, 0,            2'b01, 2'b00, 1, 32'h100, 0);
    tbl[5]  = mk(2'b11, 1, 0, 0,            alt1,  2'b00, 1, a1,      0);
    tbl[6]  = mk(2'b11, 1, 0, 0,            2'b01, 2'b00, 1, 32'h100, 0);
    tbl[7]  = mk(2'b11, 1, 0, 0,            2'b00, 2'b00, 0, a1,      0);
    tbl[8]  = mk(2'b11, 1, 1, 32'h11,       2'b00, alt1,  0, a1,      0);
    tbl[9]  = mk(2'b11, 1, 0, 0,            alt1,  2'b00, 1, a1,      0);
    tbl[10] = mk(2'b00, 0, 1, 32'h31,       2'b00, 2'b01, 0, 32'h0,   0);
    tbl[11] = mk(2'b00, 0, 1, 32'h32,       2'b00, alt1,  0, 32'h0,   0);
    tbl[12] = mk(2'b00, 0, 1, 32'h33,       2'b00, 2'b01, 0, 32'h0,   0);
    tbl[13] = mk(2'b00, 0, 1, 32'h34,       2'b00, alt1,  0, 32'h0,   0);
    tbl[14] = mk(2'b01, 1, 0, 0,            2'b01, 2'b00, 1, 32'h100, 0);
    tbl[15] = mk(2'b10, 1, 0, 0,            2'b10, 2'b00, 1, 32'h200, 0);
    tbl[16] = mk(2'b01, 1, 1, 32'h22,       2'b01, 2'b01, 1, 32'h100, 0);
    tbl[17] = mk(2'b00, 0, 1, 32'h23,       2'b00, 2'b10, 0, 32'h0,   0);
    tbl[18] = mk(2'b00, 0, 1, 32'h24,       2'b00, 2'b01, 0, 32'h0,   0);
    tbl[19] = mk(2'b00, 0, 1, 32'h25,       2'b00, 2'b00, 0, 32'h0,   0);
    tbl[20] = mk(2'b00, 0, 0, 0,            2'b00, 2'b00, 0, 32'h0,   1);

    // Outputs must be forced to reset values even with activity on the inputs
    drive(2'b11, 1, 1, 32'h5555_AAAA);
    #2;
    chk_reset_outputs("reset");
    next_cycle();
    next_cycle();
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      #3;
      chk($sformatf("v%0d_gnt", i),    32'(gnt_o),     32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid_o),  32'(tbl[i].e_rv));
      chk($sformatf("v%0d_memreq", i), 32'(mem_req_o), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_addr", i),   mem_addr_o,     tbl[i].e_addr);
      chk($sformatf("v%0d_err", i),    32'(err_o),     32'(tbl[i].e_err));
      if (tbl[i].e_rv != 2'b00) chk($sformatf("v%0d_rdata", i), rdata_o, tbl[i].rdata);
      next_cycle();
    end

    // Sticky error survives idle cycles
    drive(2'b00, 0, 0, 0);
    next_cycle();
    next_cycle();
    chk("err_sticky", 32'(err_o), 32'h1);

    // Reset in the middle of a burst
    drive(2'b11, 1, 0, 0);
    next_cycle();
    next_cycle();
    drive(2'b11, 1, 1, 32'h77);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    next_cycle();
    rst = 1'b1;
    drive(2'b11, 1, 0, 0);
    #3;
    chk("midrst_first_gnt", 32'(gnt_o), 32'h1);
    next_cycle();
    drive(2'b00, 0, 1, 32'h88);
    #3;
    chk("midrst_pop", 32'(rvalid_o), 32'h1);
    next_cycle();
    drive(2'b00, 0, 1, 32'h99);
    #3;
    chk("midrst_dropped_ids", 32'(rvalid_o), 32'h0);
    next_cycle();
    drive(2'b00, 0, 0, 0);
    #3;
    chk("midrst_err", 32'(err_o), 32'h1);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;

    // Randomized traffic against the queue-based model
    rr_last = 1;
    for (int c = 0; c < 400; c++) begin
      logic g, rv;
      logic [31:0] rd;
      int w;
      logic e_req;
      logic [1:0] e_gnt, e_rv;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(1, 0) == 1)) begin
          pend[p]   = 1'b1;
          paddr[p]  = $urandom;
          pwdata[p] = $urandom;
          pweb[p]   = 1'($urandom_range(1, 0));
        end
      end
      g  = ($urandom_range(3, 0) != 0);
      rv = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
      rd = $urandom;
      req_i = {pend[1], pend[0]};
      addr_i = {paddr[1], paddr[0]};
      wdata_i = {pwdata[1], pwdata[0]};
      web_i = {pweb[1], pweb[0]};
      mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;

      w = -1;
      if (FIXED) begin
        for (int p = 1; p >= 0; p--) if (pend[p]) w = p;
      end else begin
        for (int k = 2; k >= 1; k--) if (pend[(rr_last + k) % 2]) w = (rr_last + k) % 2;
      end
      e_req = (w >= 0) && (mq.size() < 4);
      e_gnt = (e_req && g) ? 2'(1 << w) : 2'b00;
      e_rv  = rv ? 2'(1 << mq[0]) : 2'b00;

      #3;
      chk("rnd_memreq", 32'(mem_req_o), 32'(e_req));
      chk("rnd_gnt",    32'(gnt_o),     32'(e_gnt));
      chk("rnd_rvalid", 32'(rvalid_o),  32'(e_rv));
      chk("rnd_addr",   mem_addr_o,     (w >= 0) ? paddr[w] : 32'h0);
      chk("rnd_wdata",  mem_wdata_o,    (w >= 0) ? pwdata[w] : 32'h0);
      chk("rnd_web",    32'(mem_web_o), (w >= 0) ? 32'(pweb[w]) : 32'h1);
      if (rv) chk("rnd_rdata", rdata_o, rd);
      next_cycle();

      if (rv) void'(mq.pop_front());
      if (e_gnt != 2'b00) begin
        mq.push_back(w);
        pend[w] = 1'b0;
        rr_last = w;
      end
    end
    chk("rnd_err_clear", 32'(err_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_arbiter_bridge.md
# obi_arbiter_bridge

Parametrised N-port OBI bridge that lets several CPU-side requestors (instruction fetcher, load/store unit, debug or DMA port) share one memory port. It arbitrates requests, forwards the winner's address/write data to memory, tracks up to MAX_OUTSTANDING in-flight transactions in an ID FIFO, and routes in-order responses back to the issuing port. It sits between the CPU-side fetch/LSU blocks and a single SRAM/SSRAM controller.

## Interface
Parameters:
- NUM_PORTS, 2, number of requestor ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTSTANDING, 4, ID FIFO depth (power of two, 2..16)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- req_i  in  NUM_PORTS  per-port request
- addr_i  in  NUM_PORTS*ADDR_W  per-port address, port p at bits [p*ADDR_W +: ADDR_W]
- web_i  in  NUM_PORTS  per-port write enable, active-low
- wdata_i  in  NUM_PORTS*DATA_W  per-port write data
- gnt_o  out  NUM_PORTS  per-port grant (one-hot or zero)
- rvalid_o  out  NUM_PORTS  per-port response valid (one-hot or zero)
- rdata_o  out  DATA_W  response data, broadcast to all ports
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_W  memory address
- mem_web_o  out  1  memory write enable, active-low
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory ready/grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory read data
- err_o  out  1  sticky protocol error: response with no outstanding transaction

## Operation
- Handshake: transaction accepted on a cycle where mem_req_o && mem_gnt_i.
- mem_req_o = (any req_i) && (count < MAX_OUTSTANDING). When FIFO full, no request is presented and no gnt_o asserted.
- Winner selected combinationally; mem_addr_o/mem_web_o/mem_wdata_o = winner's fields; when no request, mem_addr_o=0, mem_web_o=1, mem_wdata_o=0.
- gnt_o[w] = mem_req_o && mem_gnt_i for winner w only.
- On handshake: winner index pushed into ID FIFO (writes too — memory returns rvalid for writes; rdata ignored by requestor).
- On mem_rvalid_i with count>0: pop head h; rvalid_o[h]=1; rdata_o=mem_rdata_i.
- On mem_rvalid_i with count==0: no pop, rvalid_o=0, err_o set; cleared only by reset.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Arbitration (default round-robin): rr_last holds last granted index; search starts at rr_last+1 modulo NUM_PORTS, wrapping. rr_last updates only on handshake; a request that is not granted by memory keeps its priority.
- Requestors must hold req_i/addr_i/web_i/wdata_i stable until gnt_o.
- FIFO pointers wrap at MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.

## Timing
- Request path combinational: req_i -> mem_req_o and mem_gnt_i -> gnt_o in the same cycle, zero added latency.
- Response path combinational: mem_rvalid_i -> rvalid_o same cycle; memory must return rvalid at least one cycle after the corresponding grant.
- FIFO/count/rr_last/err update on rising clk.
- Reset (rst low, asynchronous): count=0, pointers=0, rr_last=NUM_PORTS-1 (port 0 wins first), err_o=0; gnt_o=0, rvalid_o=0, mem_req_o=0, mem_addr_o=0, mem_web_o=1, mem_wdata_o=0, rdata_o=0 while rst low.
- Reset mid-operation drops all outstanding IDs; memory is reset with the bridge. Any rvalid arriving after release with empty FIFO sets err_o.

## Configuration
- OBI_BRIDGE_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_last unused.
- Not defined: round-robin as above.

## Test plan
- Single port 0 read addr 0x100, mem_gnt_i=1, rvalid 2 cycles later with 0xDEADBEEF -> gnt_o=01 same cycle, rvalid_o=01, rdata_o=0xDEADBEEF, count back to 0.
- Both ports request continuously, mem_gnt_i=1 (round-robin) -> grants 01,10,01,10; with OBI_BRIDGE_FIXED_PRIO_EN -> 01 every cycle.
- MAX_OUTSTANDING=4, grants each cycle, no rvalid -> 4 handshakes, then mem_req_o=0 and gnt_o=0 until one rvalid; next cycle request resumes.
- Interleaved grants port1,port0,port1 then three rvalids -> rvalid_o sequence 10,01,10 in order.
- Grant and rvalid same cycle at count=2 -> count stays 2, correct head routed.
- mem_rvalid_i with empty FIFO -> rvalid_o=0, err_o=1 held until rst low; assert rst mid-burst -> all outputs at reset values immediately.
